// File: rtl/fetch_ctrl.sv
// fetch_ctrl: loads a program into instruction memory, then sequences PC fetch until a halt opcode.
module fetch_ctrl #(
  parameter logic [5:0] HALT_OPCODE = 6'b000000,
  parameter int unsigned FILL_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  input  logic [9:0]  pc_address,
  input  logic [5:0]  op_code,
  input  logic        stall_req,
  output logic        im_en_write,
  output logic [9:0]  im_address,
  output logic [15:0] im_data_in,
  output logic        pc_reset,
  output logic        pc_stall,
  output logic        halted,
  output logic [10:0] load_count,
  output logic [2:0]  state
);
  localparam int FW = $clog2(FILL_DELAY + 2);
  localparam logic [FW-1:0] FD = FW'(FILL_DELAY);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, FLUSH = 3'd2, RUN = 3'd3, HALT = 3'd4} state_t;
  state_t cur, nxt;
  logic [10:0] lcnt, lcnt_n;
  logic [FW-1:0] fill, fill_n;
  logic acc, run_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= IDLE;
      lcnt <= '0;
      fill <= '0;
    end else begin
      cur  <= nxt;
      lcnt <= lcnt_n;
      fill <= fill_n;
    end
  end
  always_comb begin
    nxt    = cur;
    lcnt_n = lcnt;
    fill_n = fill;
    acc    = (cur == LOAD) && ld_valid;
    run_ok = (cur == RUN) && !stall_req;
    if ((cur == IDLE || cur == HALT) && start) begin
      nxt    = LOAD;
      lcnt_n = '0;
    end
    if (acc) begin
      lcnt_n = lcnt + 11'd1;
      if (ld_last || lcnt == 11'd1023) nxt = FLUSH;
    end
    if (cur == FLUSH) begin
      nxt    = RUN;
      fill_n = '0;
    end
    // op_code is only trusted once the IM read and IR latch have refilled after pc_reset
    if (run_ok && fill != FD) fill_n = fill + 1'b1;
    if (run_ok && fill == FD && op_code == HALT_OPCODE) nxt = HALT;
  end
  assign ld_ready    = cur == LOAD;
  assign im_en_write = acc;
  assign im_address  = (cur == RUN || cur == HALT) ? pc_address : lcnt[9:0];
  assign im_data_in  = ld_data;
  assign pc_reset    = cur == FLUSH;
  assign pc_stall    = (cur == RUN) ? stall_req : 1'b1;
  assign halted      = cur == HALT;
  assign load_count  = lcnt;
  assign state       = cur;
endmodule
